hca_subtractor_pipe: RTL and testbench

//   Pipelined two-operand subtractor D = X - Y - BIN. Uses a Han-Carlson parallel-prefix borrow network:

---
 rtl/hca_subtractor_pipe.sv | 180 ++++++++++++++++++
 tb/tb_hca_subtractor_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hca_subtractor_pipe.sv
// Pipelined subtractor D = X - Y - BIN using a Han-Carlson prefix borrow network.
// Latency: 3 register stages; an item captured into stage 1 on a clock edge is on the outputs after the 3rd edge.
// Backpressure: each stage's valid/ready collapses bubbles; IN_READY drops only when all 3 stages hold items and OUT_READY=0.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   IN_VALID / IN_READY   input handshake for X, Y, BIN
//   X, Y [W-1:0], BIN     minuend, subtrahend, borrow-in
//   OUT_VALID / OUT_READY output handshake for D, BOUT, OVF, ZERO
//   D [W-1:0]             difference modulo 2^W
//   BOUT                  unsigned borrow-out (X < Y + BIN)
//   OVF                   signed overflow
//   ZERO                  D == 0
module hca_subtractor_pipe #(
  parameter int W = 29
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         BIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] D,
  output logic         BOUT,
  output logic         OVF,
  output logic         ZERO
);

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
  } gp_t;

  // Level 1: every odd bit absorbs its even neighbour below.
  function automatic gp_t level_first(input gp_t a);
    gp_t r;
    r = a;
    for (int i = 1; i < W; i += 2) begin
      r.g[i] = a.g[i] | (a.p[i] & a.g[i-1]);
      r.p[i] = a.p[i] & a.p[i-1];
    end
    return r;
  endfunction

  // Kogge-Stone over the odd bits only, spans 2, 4, 8, ... below W.
  // After these levels every odd bit i holds the group term for bits [0..i].
  function automatic gp_t levels_odd(input gp_t a);
    gp_t cur;
    gp_t nxt;
    cur = a;
    for (int s = 2; s < W; s = s * 2) begin
      nxt = cur;
      for (int i = 1; i < W; i += 2) begin
        if (i >= s) begin
          nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i-s]);
          nxt.p[i] = cur.p[i] & cur.p[i-s];
        end
      end
      cur = nxt;
    end
    return cur;
  endfunction

  // Final level: even bits from 2 upward pick up the completed odd group below.
  function automatic gp_t level_last(input gp_t a);
    gp_t r;
    r = a;
    for (int i = 2; i < W; i += 2) begin
      r.g[i] = a.g[i] | (a.p[i] & a.g[i-1]);
      r.p[i] = a.p[i] & a.p[i-1];
    end
    return r;
  endfunction

  // Flow control
  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3   = ~r_v3 | OUT_READY;
  assign w_adv2   = ~r_v2 | w_adv3;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign IN_READY = w_adv1;

  // Stage 0 -> 1: generate/propagate on X and ~Y, carry-in is ~BIN.
  gp_t w_gp0;
  gp_t w_gp1;
  assign w_gp0.g = X & ~Y;
  assign w_gp0.p = X ^ ~Y;
  assign w_gp1   = level_first(w_gp0);

  gp_t          r1_gp;
  logic [W-1:0] r1_p0;
  logic         r1_cin, r1_xs, r1_ys;

  // Stage 1 -> 2
  gp_t w_gp2;
  assign w_gp2 = levels_odd(r1_gp);

  gp_t          r2_gp;
  logic [W-1:0] r2_p0;
  logic         r2_cin, r2_xs, r2_ys;

  // Stage 2 -> 3: last prefix level, carries, sum and flags.
  gp_t          w_gp3;
  logic [W:0]   w_c;
  logic [W-1:0] w_d;
  logic         w_bout, w_ovf, w_zero;

  assign w_gp3 = level_last(r2_gp);

  always_comb begin
    w_c    = '0;
    w_c[0] = r2_cin;
    for (int i = 1; i <= W; i++) begin
      w_c[i] = w_gp3.g[i-1] | (w_gp3.p[i-1] & r2_cin);
    end
  end

  assign w_d    = r2_p0 ^ w_c[W-1:0];
  // Carry-out of X + ~Y + ~BIN set means no borrow.
  assign w_bout = ~w_c[W];
  assign w_ovf  = (r2_xs ^ r2_ys) & (w_d[W-1] ^ r2_xs);
  assign w_zero = ~|w_d;

  logic [W-1:0] r_d;
  logic         r_bout, r_ovf, r_zero;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      // Data registers only load with a valid item so bubbles never disturb them.
      if (w_adv1) begin
        r_v1 <= IN_VALID;
        if (IN_VALID) begin
          r1_gp  <= w_gp1;
          r1_p0  <= w_gp0.p;
          r1_cin <= ~BIN;
          r1_xs  <= X[W-1];
          r1_ys  <= Y[W-1];
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r2_gp  <= w_gp2;
          r2_p0  <= r1_p0;
          r2_cin <= r1_cin;
          r2_xs  <= r1_xs;
          r2_ys  <= r1_ys;
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_d    <= w_d;
          r_bout <= w_bout;
          r_ovf  <= w_ovf;
          r_zero <= w_zero;
        end
      end
    end
  end

  assign OUT_VALID = r_v3;
  assign D         = r_d;
  assign BOUT      = r_bout;
  assign OVF       = r_ovf;
  assign ZERO      = r_zero;

endmodule

// File: tb/tb_hca_subtractor_pipe.sv
// Self-checking bench for hca_subtractor_pipe (W=29): directed cases, stall stream,
// mid-flight reset and a long random run against an arithmetic reference queue.
module tb_hca_subtractor_pipe;
  localparam int W = 29;

  logic         CLK, RST;
  logic         IN_VALID, IN_READY;
  logic [W-1:0] X, Y;
  logic         BIN;
  logic         OUT_VALID, OUT_READY;
  logic [W-1:0] D;
  logic         BOUT, OVF, ZERO;

  hca_subtractor_pipe #(.W(W)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .BIN(BIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .D(D), .BOUT(BOUT), .OVF(OVF), .ZERO(ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Expected results of accepted, not yet emitted items: {BOUT, OVF, ZERO, D}
  logic [W+2:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain arithmetic reference: {BOUT,D} = {0,X} - Y - BIN.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    logic [W:0]   diff;
    logic [W-1:0] d;
    logic         ovf;
    diff = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b};
    d    = diff[W-1:0];
    ovf  = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    return {diff[W], ovf, (d == '0), d};
  endfunction

  // One clock cycle: drive inputs, check against the model, account transfers.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic b, input logic ordy);
    logic in_fire, out_fire;
    IN_VALID  = iv;
    X         = x;
    Y         = y;
    BIN       = b;
    OUT_READY = ordy;
    #1;
    chk("in_ready", {63'd0, IN_READY}, {63'd0, (q.size() < 3) || ordy});
    if (OUT_VALID) begin
      if (q.size() == 0) chk("spurious_valid", {63'd0, OUT_VALID}, 64'd0);
      else chk("result", {{(61-W){1'b0}}, BOUT, OVF, ZERO, D}, {{(61-W){1'b0}}, q[0]});
    end
    in_fire  = iv & IN_READY;
    out_fire = OUT_VALID & ordy;
    if (out_fire && q.size() > 0) void'(q.pop_front());
    if (in_fire) q.push_back(model(x, y, b));
    @(posedge CLK);
    #1;
  endtask

  // Single item through an empty pipe: latency and explicit constant results.
  task automatic dir_test(input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
    cycle(1'b1, x, y, b, 1'b1);
    chk("lat_e1", {63'd0, OUT_VALID}, 64'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("lat_e2", {63'd0, OUT_VALID}, 64'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("lat_e3", {63'd0, OUT_VALID}, 64'd1);
    chk("dir_d", {{(64-W){1'b0}}, D}, {{(64-W){1'b0}}, ed});
    chk("dir_flags", {61'd0, BOUT, OVF, ZERO}, {61'd0, eb, eo, ez});
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
    chk("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_out", {{(61-W){1'b0}}, BOUT, OVF, ZERO, D}, 64'd0);
    RST = 1'b0;
    q.delete();
    #1;
    chk("rst_ready", {63'd0, IN_READY}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         saw_block;
    int           sent;
    logic [W-1:0] rx, ry;

    RST = 1'b1; IN_VALID = 1'b0; X = '0; Y = '0; BIN = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    do_reset(2);

    // Directed arithmetic cases
    dir_test(29'd5, 29'd3, 1'b0, 29'd2, 1'b0, 1'b0, 1'b0);
    dir_test(29'd0, 29'd1, 1'b0, 29'h1FFFFFFF, 1'b1, 1'b0, 1'b0);
    dir_test(29'h0FFFFFFF, 29'h1FFFFFFF, 1'b0, 29'h10000000, 1'b1, 1'b1, 1'b0);
    dir_test(29'h10000000, 29'd1, 1'b0, 29'h0FFFFFFF, 1'b0, 1'b1, 1'b0);
    dir_test(29'h1234567, 29'h1234567, 1'b1, 29'h1FFFFFFF, 1'b1, 1'b0, 1'b0);
    dir_test(29'h0ABCDEF, 29'h0ABCDEF, 1'b0, 29'd0, 1'b0, 1'b0, 1'b1);
    dir_test(29'd0, 29'd0, 1'b1, 29'h1FFFFFFF, 1'b1, 1'b0, 1'b0);

    // Stream 10 items with the consumer stalled for cycles 2..7.
    saw_block = 1'b0;
    sent = 0;
    for (int c = 0; c < 100 && (sent < 10 || q.size() > 0); c++) begin
      logic ordy;
      ordy = !(c >= 2 && c <= 7);
      if (sent < 10) begin
        IN_VALID = 1'b1; OUT_READY = ordy;
        #0;
        if (!IN_READY) saw_block = 1'b1;
        if (IN_READY) sent++;
        cycle(1'b1, W'(29'h100 * (sent + 1)), W'(sent), 1'b0, ordy);
      end else begin
        cycle(1'b0, '0, '0, 1'b0, ordy);
      end
    end
    chk("stream_backpressure", {63'd0, saw_block}, 64'd1);
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Reset with two items in flight: they must never appear.
    cycle(1'b1, 29'd100, 29'd1, 1'b0, 1'b1);
    cycle(1'b1, 29'd200, 29'd2, 1'b0, 1'b1);
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      chk("flush_valid", {63'd0, OUT_VALID}, 64'd0);
    end
    dir_test(29'd1000, 29'd1, 1'b0, 29'd999, 1'b0, 1'b0, 1'b0);

    // Random traffic with random stalls on both sides.
    for (int c = 0; c < 10000; c++) begin
      rx = W'($urandom());
      ry = W'($urandom());
      if ($urandom_range(7) == 0) ry = rx;
      cycle(1'($urandom_range(3) != 0), rx, ry, 1'($urandom_range(1)),
            1'($urandom_range(3) != 0));
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("random_drained", 64'(q.size()), 64'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("idle_valid", {63'd0, OUT_VALID}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
